serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must reach WIDTH, hence one bit beyond $clog2.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the serial adder's bit slice.
module full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic carry_out
);

    assign sum_out   = a_in ^ b_in ^ c_in;
    assign carry_out = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes LSB-first over WIDTH cycles,
// then publishes {carry_out, sum_out} with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start_in; operands captured on the accepting edge
// ADD   | one bit per edge, WIDTH edges total
// DONE  | results just updated; returns to IDLE, start_in ignored
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [WIDTH-1:0] r_work, w_work_nxt;
    logic             r_carry, w_carry_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_sum, w_sum_nxt;
    logic             r_cout, w_cout_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_work_shift;

    full_adder u_full_adder (
        .a_in      (r_a[0]),
        .b_in      (r_b[0]),
        .c_in      (r_carry),
        .sum_out   (w_fa_sum),
        .carry_out (w_fa_cout)
    );

    // Sum bits enter at the MSB so the LSB-first result ends up aligned.
    assign w_work_shift = {w_fa_sum, r_work[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_work_nxt  = r_work;
        w_carry_nxt = r_carry;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_a_nxt     = a_in;
                    w_b_nxt     = b_in;
                    w_carry_nxt = c_in;
                    w_work_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                w_a_nxt     = r_a >> 1;
                w_b_nxt     = r_b >> 1;
                w_work_nxt  = w_work_shift;
                w_carry_nxt = w_fa_cout;
                w_cnt_nxt   = r_cnt + CW'(1);
                if (r_cnt == LAST_BIT) begin
                    w_sum_nxt   = w_work_shift;
                    w_cout_nxt  = w_fa_cout;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_work  <= w_work_nxt;
            r_carry <= w_carry_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign sum_out   = r_sum;
    assign carry_out = r_cout;
    assign busy_out  = r_busy;
    assign done_out  = r_done;

endmodule
